// File: rtl/mcu_timer_array.sv
// Multi-channel down-counting timer peripheral on the mcu register bus.
// Per-channel prescaler, one-shot/periodic modes, shadowed count reads, shared IRQ.
module mcu_timer_array #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(NUM_CH*8)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_sel,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_data,
    output logic              o_irq_n
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0]  count_q    [NUM_CH];
    logic [WIDTH-1:0]  count_d    [NUM_CH];
    logic [WIDTH-1:0]  reload_q   [NUM_CH];
    logic [WIDTH-1:0]  reload_d   [NUM_CH];
    logic [WIDTH-1:0]  shadow_q   [NUM_CH];
    logic [WIDTH-1:0]  shadow_d   [NUM_CH];
    logic [7:0]        prescale_q [NUM_CH];
    logic [7:0]        prescale_d [NUM_CH];
    logic [7:0]        pcnt_q     [NUM_CH];
    logic [7:0]        pcnt_d     [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] ie_q, ie_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [7:0]        data_q, data_d;
    logic              irq_n_q, irq_n_d;

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] tick;
    logic [ADDR_W-1:0] ch_idx;
    logic [2:0]        off;
    logic              wr_en;
    logic              rd_en;

    assign wr_en  = i_sel & ~i_rw;
    assign rd_en  = i_sel & i_rw;
    assign off    = i_addr[2:0];
    assign ch_idx = i_addr >> 3;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c]  = (ch_idx == ADDR_W'(c));
            tick[c] = en_q[c] && (pcnt_q[c] == prescale_q[c]);
        end
    end

    always_comb begin
        data_d = data_q;
        if (rd_en) data_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            count_d[c]    = count_q[c];
            reload_d[c]   = reload_q[c];
            shadow_d[c]   = shadow_q[c];
            prescale_d[c] = prescale_q[c];
            pcnt_d[c]     = pcnt_q[c];
            en_d[c]       = en_q[c];
            mode_d[c]     = mode_q[c];
            ie_d[c]       = ie_q[c];
            done_d[c]     = done_q[c];

            if (en_q[c]) pcnt_d[c] = tick[c] ? 8'd0 : pcnt_q[c] + 8'd1;

            if (tick[c]) begin
                if (count_q[c] != '0) begin
                    count_d[c] = count_q[c] - WIDTH'(1);
                end else begin
                    done_d[c] = 1'b1;
                    if (mode_q[c]) count_d[c] = reload_q[c];
                    else           en_d[c]    = 1'b0;
                end
            end

            // Register writes land after the tick so LOAD and CTRL override it.
            if (wr_en && hit[c]) begin
                case (off)
                    3'd4: begin
                        en_d[c]   = i_data[0];
                        mode_d[c] = i_data[1];
                        ie_d[c]   = i_data[2];
                        if (i_data[0] && !en_q[c]) pcnt_d[c] = '0;
                        if (i_data[3]) begin
                            count_d[c] = reload_q[c];
                            pcnt_d[c]  = '0;
                        end
                    end
                    3'd5: begin
                        if (i_data[0] && !(tick[c] && count_q[c] == '0))
                            done_d[c] = 1'b0;
                    end
                    3'd6: begin
                        prescale_d[c] = i_data;
                        pcnt_d[c]     = '0;
                    end
                    default: ;
                endcase
                for (int b = 0; b < NB; b++) begin
                    if (off == 3'(b)) reload_d[c][b*8 +: 8] = i_data;
                end
            end

            if (rd_en && hit[c]) begin
                case (off)
                    3'd0: begin
                        data_d      = count_q[c][7:0];
                        shadow_d[c] = count_q[c];
                    end
                    3'd4:    data_d = {5'b0, ie_q[c], mode_q[c], en_q[c]};
                    3'd5:    data_d = {6'b0, en_q[c], done_q[c]};
                    3'd6:    data_d = prescale_q[c];
                    default: ;
                endcase
                for (int b = 1; b < NB; b++) begin
                    if (off == 3'(b)) data_d = shadow_q[c][b*8 +: 8];
                end
            end
        end
        irq_n_d = ~|(done_q & ie_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c]    <= '0;
                reload_q[c]   <= '0;
                shadow_q[c]   <= '0;
                prescale_q[c] <= '0;
                pcnt_q[c]     <= '0;
            end
            en_q    <= '0;
            mode_q  <= '0;
            ie_q    <= '0;
            done_q  <= '0;
            data_q  <= '0;
            irq_n_q <= 1'b1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c]    <= count_d[c];
                reload_q[c]   <= reload_d[c];
                shadow_q[c]   <= shadow_d[c];
                prescale_q[c] <= prescale_d[c];
                pcnt_q[c]     <= pcnt_d[c];
            end
            en_q    <= en_d;
            mode_q  <= mode_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            data_q  <= data_d;
            irq_n_q <= irq_n_d;
        end
    end

    assign o_data  = data_q;
    assign o_irq_n = irq_n_q;

endmodule

// File: tb/tb_mcu_timer_array.sv
// Scoreboard bench for mcu_timer_array (NUM_CH=2, WIDTH=16).
// Stimulus queues expected read data / IRQ levels; a negedge monitor compares.
module tb_mcu_timer_array;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_sel = 1'b0;
    logic          i_rw = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [7:0]    i_data = '0;
    logic [7:0]    o_data;
    logic          o_irq_n;

    typedef struct {
        logic [7:0] exp;
        bit         is_irq;
        string      name;
    } ent_t;

    ent_t rdq[$];
    ent_t nowq[$];
    int   tests = 0;
    int   fails = 0;
    logic rd_pend = 1'b0;

    mcu_timer_array #(.NUM_CH(2), .WIDTH(16)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_sel   (i_sel),
        .i_rw    (i_rw),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .o_data  (o_data),
        .o_irq_n (o_irq_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_pend <= i_sel & i_rw;

    always @(negedge clk) begin
        ent_t e;
        logic [7:0] act;
        if (rd_pend) begin
            tests++;
            if (rdq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_read: got %02h, no expectation", o_data);
            end else begin
                e = rdq.pop_front();
                if (o_data !== e.exp) begin
                    fails++;
                    $display("FAIL %s: got %02h, expected %02h", e.name, o_data, e.exp);
                end
            end
        end
        while (nowq.size() > 0) begin
            e = nowq.pop_front();
            act = e.is_irq ? {7'b0, o_irq_n} : o_data;
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL %s: got %02h, expected %02h", e.name, act, e.exp);
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        i_sel = 1'b1; i_rw = 1'b0; i_addr = a; i_data = d;
        @(posedge clk); #1;
        i_sel = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [7:0] e, input string n);
        i_sel = 1'b1; i_rw = 1'b1; i_addr = a;
        rdq.push_back('{e, 1'b0, n});
        @(posedge clk); #1;
        i_sel = 1'b0; i_rw = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_irq(input logic e, input string n);
        nowq.push_back('{{7'b0, e}, 1'b1, n});
    endtask

    task automatic chk_data(input logic [7:0] e, input string n);
        nowq.push_back('{e, 1'b0, n});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        i_reset = 1'b0;
        chk_irq(1'b1, "rst_irq");
        chk_data(8'h00, "rst_data");
        rd(4'd4, 8'h00, "rst_ctrl");
        rd(4'd5, 8'h00, "rst_status");
        rd(4'd6, 8'h00, "rst_prescale");

        // periodic ch0: RELOAD=3, PRESCALE=1 -> underflow every 8 clocks
        wr(4'd0, 8'd3);
        wr(4'd1, 8'd0);
        wr(4'd6, 8'd1);
        wr(4'd4, 8'h0F);
        idle(6);
        rd(4'd5, 8'h02, "t1_before_done");
        idle(1);
        chk_irq(1'b1, "t1_irq_not_yet");
        rd(4'd5, 8'h03, "t1_done");
        chk_irq(1'b0, "t1_irq_low");
        wr(4'd5, 8'h01);
        chk_irq(1'b0, "t1_irq_still_low");
        idle(1);
        chk_irq(1'b1, "t1_irq_released");
        idle(4);
        rd(4'd5, 8'h02, "t1_before_done2");
        rd(4'd5, 8'h03, "t1_done2");
        rd(4'd0, 8'h03, "t1_reloaded");
        wr(4'd4, 8'h00);
        wr(4'd5, 8'h01);

        // one-shot ch1: RELOAD=2, PRESCALE=0
        wr(4'd8, 8'd2);
        wr(4'd9, 8'd0);
        wr(4'd12, 8'h09);
        idle(2);
        rd(4'd13, 8'h02, "t2_running");
        rd(4'd13, 8'h01, "t2_done_stopped");
        chk_irq(1'b1, "t2_no_irq");
        wr(4'd13, 8'h01);
        idle(20);
        rd(4'd13, 8'h00, "t2_no_more_done");
        rd(4'd8, 8'h00, "t2_count_zero");
        rd(4'd12, 8'h00, "t2_ctrl");

        // shadowed multi-byte count read
        wr(4'd0, 8'h00);
        wr(4'd1, 8'h01);
        wr(4'd6, 8'h00);
        wr(4'd4, 8'h0B);
        rd(4'd0, 8'h00, "t3_lo");
        idle(1);
        rd(4'd1, 8'h01, "t3_shadow_hi");
        rd(4'd2, 8'h00, "t3_byte2");
        wr(4'd4, 8'h00);

        // W1C on the underflow edge: set wins
        wr(4'd0, 8'd2);
        wr(4'd1, 8'd0);
        wr(4'd4, 8'h0B);
        idle(2);
        wr(4'd5, 8'h01);
        rd(4'd5, 8'h03, "t4_set_wins");
        rd(4'd4, 8'h03, "t4_ctrl_load_reads0");
        wr(4'd4, 8'h00);
        wr(4'd5, 8'h01);
        rd(4'd5, 8'h00, "t4_cleared");

        // RELOAD write does not disturb count; LOAD beats tick
        wr(4'd0, 8'd9);
        wr(4'd4, 8'h0B);
        wr(4'd0, 8'd5);
        rd(4'd0, 8'h08, "t4_reload_no_disturb");
        wr(4'd4, 8'h0B);
        rd(4'd0, 8'h05, "t4_load_beats_tick");
        wr(4'd4, 8'h00);

        // IRQ masking: ch0 IE=1 periodic, ch1 IE=0 one-shot
        wr(4'd0, 8'd1);
        wr(4'd1, 8'd0);
        wr(4'd6, 8'd0);
        wr(4'd4, 8'h0F);
        wr(4'd12, 8'h09);
        chk_irq(1'b1, "t5_irq_k1");
        idle(1);
        chk_irq(1'b1, "t5_irq_k2");
        idle(1);
        chk_irq(1'b0, "t5_irq_ch0");
        wr(4'd4, 8'h04);
        wr(4'd5, 8'h01);
        chk_irq(1'b0, "t5_irq_pre_clear");
        idle(1);
        chk_irq(1'b1, "t5_irq_ch1_masked");
        rd(4'd13, 8'h01, "t5_ch1_done");
        rd(4'd5, 8'h00, "t5_ch0_clear");
        rd(4'd4, 8'h04, "t5_ch0_ctrl");
        rd(4'd7, 8'h00, "t5_reserved0");
        rd(4'd15, 8'h00, "t5_reserved1");
        rd(4'd3, 8'h00, "t5_byte3");

        // reset mid-count
        wr(4'd12, 8'h04);
        wr(4'd0, 8'h20);
        wr(4'd4, 8'h0F);
        chk_irq(1'b0, "t6_irq_before_rst");
        rd(4'd0, 8'h20, "t6_count_before_rst");
        i_reset = 1'b1;
        idle(1);
        i_reset = 1'b0;
        chk_irq(1'b1, "t6_irq_after_rst");
        chk_data(8'h00, "t6_data_after_rst");
        rd(4'd1, 8'h00, "t6_shadow");
        rd(4'd0, 8'h00, "t6_count");
        rd(4'd4, 8'h00, "t6_ctrl");
        rd(4'd5, 8'h00, "t6_status");
        rd(4'd6, 8'h00, "t6_prescale");
        rd(4'd12, 8'h00, "t6_ch1_ctrl");
        idle(40);
        rd(4'd5, 8'h00, "t6_no_done");
        rd(4'd13, 8'h00, "t6_ch1_no_done");
        chk_irq(1'b1, "t6_irq_idle");

        idle(3);
        if (rdq.size() != 0 || nowq.size() != 0) begin
            fails += rdq.size() + nowq.size();
            $display("FAIL pending_checks: got %0d left, expected 0",
                     rdq.size() + nowq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
